spi_ram_bridge: RTL and testbench
=================================

# spi_ram_bridge

Parametrised SPI-slave-to-RAM bridge and the successor of the fixed 10-bit SPI slave + 256x8 RAM wrapper pair. It supports configurable data, address and memory depth, and optional address auto-increment. Multi-frame bursts run under a single SS_n assertion, and mid-frame aborts are detected. It sits between the external SPI pins and an internal single-port memory, and is sampled entirely on the system clock.

## Interface
- DATA_WIDTH, 8: memory word width; frame payload width.
- ADDR_WIDTH, 8: address register width; must be <= DATA_WIDTH.
- MEM_DEPTH, 256: number of words; must be <= 2**ADDR_WIDTH.
- AUTO_INC, 1: 1 = address post-increments after each WR_DATA/RD_DATA; 0 = address is held.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- SS_n  in  1  slave select, active low.
- MOSI  in  1  serial data in, MSB first.
- MISO  out  1  serial data out, MSB first.
- busy  out  1  high whenever state != IDLE.
- frame_err  out  1  one-cycle pulse on a truncated frame.

## Operation
- Frame width is FW = DATA_WIDTH+2. A frame is {cmd[1:0], payload[DATA_WIDTH-1:0]}, MSB first.
- Commands:
  - 00 WR_ADDR: wr_addr <= payload[ADDR_WIDTH-1:0].
  - 01 WR_DATA: mem[wr_addr] <= payload.
  - 10 RD_ADDR: rd_addr <= payload[ADDR_WIDTH-1:0].
  - 11 RD_DATA: payload ignored; mem[rd_addr] is shifted out on MISO.
- Auto-increment (AUTO_INC=1) applies after WR_DATA and RD_DATA. The address wraps from MEM_DEPTH-1 to 0.
- Out-of-range address (addr >= MEM_DEPTH): the write is dropped and a read returns all zeros. Auto-increment still applies.
- States:
  - IDLE: MISO=0. Goes to RECV on an edge that samples SS_n=0; bit_cnt<=0 and no bit is captured on that edge.
  - RECV: each edge shifts MOSI into shreg and increments bit_cnt. When the FW-th bit is captured, goes to EXEC.
  - EXEC: exactly 1 cycle; MOSI is ignored. Executes the command, and on RD_DATA loads tx_reg from memory. Next state is SEND for RD_DATA, otherwise RECV with bit_cnt=0.
  - SEND: lasts DATA_WIDTH cycles. MISO = tx_reg[MSB] combinationally, and tx_reg shifts left each cycle. MOSI is ignored. After the last bit, goes to RECV with bit_cnt=0.
- An edge sampling SS_n=1 in any state returns to IDLE on that edge, with these exceptions and effects:
  - In EXEC the command still completes.
  - In RECV with bit_cnt in 1..FW-1, frame_err pulses and nothing is executed.
  - In SEND, frame_err pulses and the read is truncated; any auto-increment already applied stands.
- RECV with bit_cnt=0 plus SS_n rising is a clean end of burst, with no error.
- Memory contents are not reset.

## Timing
- Reset values: state IDLE, wr_addr=0, rd_addr=0, bit_cnt=0, tx_reg=0, MISO=0, busy=0, frame_err=0.
- Reset has priority over every state. An asserted reset mid-frame discards the partial frame with no frame_err.
- Frame timing, with E0 as the edge that first samples SS_n=0:
  - Bits are captured on E1..E_FW.
  - EXEC occupies the cycle after E_FW.
  - The write/address update is visible from edge E_FW+1.
- Read latency: MISO carries bit DATA_WIDTH-1 in the cycle after EXEC, then one bit per cycle for DATA_WIDTH cycles. MISO is 0 outside SEND.
- Burst protocol: the master inserts 1 don't-care MOSI cycle (EXEC) after every frame. After RD_DATA it inserts DATA_WIDTH further cycles (SEND) before the next frame's first bit.
- frame_err is registered and asserts in the cycle after the aborting edge.
- busy is registered: 1 from E0+1 until the edge that returns to IDLE.

## Test plan
- Reset: drive rst_n=0 for 2 cycles during bit 4 of a frame -> MISO=0, busy=0, frame_err=0. A following WR_ADDR 0x10 decodes correctly.
- Write/read-back (defaults), one SS_n burst: 00_0x05, 01_0xA5, 10_0x05, 11_0x00 -> MISO = 1,0,1,0,0,1,0,1 in the 8 SEND cycles.
- Auto-increment wrap: WR_ADDR 0xFF, WR_DATA 0x11, WR_DATA 0x22 -> mem[0xFF]=0x11 and mem[0x00]=0x22. Then RD_ADDR 0xFF, RD_DATA, RD_DATA -> reads return 0x11 then 0x22.
- Abort: SS_n rises after 5 bits of WR_DATA 0x3C -> frame_err high for exactly 1 cycle; memory and wr_addr are unchanged; busy=0 the next cycle.
- AUTO_INC=0: WR_ADDR 0x20, WR_DATA 0x33, WR_DATA 0x44 -> mem[0x20]=0x44 and mem[0x21] is untouched.
- MEM_DEPTH=200: WR_ADDR 0xF0, WR_DATA 0x77 -> no write. RD_ADDR 0xF0, RD_DATA -> MISO all zeros.

Source files
------------

// File: rtl/spi_ram_bridge.sv
// SPI-slave-to-RAM bridge: frames of {cmd[1:0], payload} set the write/read
// addresses, write a word, or stream a word back on MISO. Everything runs on clk.
module spi_ram_bridge #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_DEPTH  = 256,
    parameter bit AUTO_INC   = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic SS_n,
    input  logic MOSI,
    output logic MISO,
    output logic busy,
    output logic frame_err
);

    localparam int FW = DATA_WIDTH + 2;
    localparam int CW = $clog2(FW + 1);
    localparam int MW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0]   LAST_W   = DEPTH_W - (ADDR_WIDTH + 1)'(1'b1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1'b1);
    localparam logic [CW-1:0]         CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0]         FW_LAST  = CW'(FW - 1);
    localparam logic [CW-1:0]         DW_LAST  = CW'(DATA_WIDTH - 1);

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        EXEC = 2'd2,
        SEND = 2'd3
    } state_t;

    state_t                  state_q;
    logic [CW-1:0]           bit_cnt_q;
    logic [FW-1:0]           shreg_q;
    logic [ADDR_WIDTH-1:0]   wr_addr_q;
    logic [ADDR_WIDTH-1:0]   rd_addr_q;
    logic [DATA_WIDTH-1:0]   tx_q;
    logic                    busy_q;
    logic                    frame_err_q;

    logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];

    logic [1:0]              cmd_d;
    logic [DATA_WIDTH-1:0]   payload_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_d;
    logic [ADDR_WIDTH-1:0]   rd_addr_d;
    logic [DATA_WIDTH-1:0]   rd_word_d;
    logic                    mem_we_d;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return ({1'b0, a} < DEPTH_W);
    endfunction

    // Post-increment wraps at the memory depth; out-of-range addresses keep counting.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
        if (!AUTO_INC) begin
            return a;
        end else if ({1'b0, a} == LAST_W) begin
            return '0;
        end else begin
            return a + ADDR_ONE;
        end
    endfunction

    // Frame decode, post-increment addresses and memory access controls.
    always_comb begin
        cmd_d     = shreg_q[FW-1:FW-2];
        payload_d = shreg_q[DATA_WIDTH-1:0];
        wr_addr_d = next_addr(wr_addr_q);
        rd_addr_d = next_addr(rd_addr_q);
        mem_we_d  = 1'b0;
        rd_word_d = '0;
        if (rst_n && (state_q == EXEC) && (cmd_d == CMD_WR_DATA) && in_range(wr_addr_q)) begin
            mem_we_d = 1'b1;
        end else begin
            mem_we_d = 1'b0;
        end
        if (in_range(rd_addr_q)) begin
            rd_word_d = mem_q[rd_addr_q[MW-1:0]];
        end else begin
            rd_word_d = '0;
        end
    end

    // Single-port storage; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_d) begin
            mem_q[wr_addr_q[MW-1:0]] <= payload_d;
        end
    end

    // Protocol FSM with registered busy/frame_err.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            tx_q        <= '0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    bit_cnt_q <= '0;
                    if (!SS_n) begin
                        state_q <= RECV;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                RECV: begin
                    if (SS_n) begin
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        bit_cnt_q   <= '0;
                        frame_err_q <= (bit_cnt_q != '0);
                    end else begin
                        shreg_q   <= {shreg_q[FW-2:0], MOSI};
                        bit_cnt_q <= bit_cnt_q + CNT_ONE;
                        if (bit_cnt_q == FW_LAST) begin
                            state_q <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    bit_cnt_q <= '0;
                    case (cmd_d)
                        CMD_WR_ADDR: wr_addr_q <= payload_d[ADDR_WIDTH-1:0];
                        CMD_WR_DATA: wr_addr_q <= wr_addr_d;
                        CMD_RD_ADDR: rd_addr_q <= payload_d[ADDR_WIDTH-1:0];
                        CMD_RD_DATA: begin
                            tx_q      <= rd_word_d;
                            rd_addr_q <= rd_addr_d;
                        end
                        default: wr_addr_q <= wr_addr_q;
                    endcase
                    // The command completes even when SS_n rises during EXEC.
                    if (SS_n) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (cmd_d == CMD_RD_DATA) begin
                        state_q <= SEND;
                    end else begin
                        state_q <= RECV;
                    end
                end
                SEND: begin
                    if (SS_n) begin
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        bit_cnt_q   <= '0;
                        frame_err_q <= 1'b1;
                    end else begin
                        tx_q      <= {tx_q[DATA_WIDTH-2:0], 1'b0};
                        bit_cnt_q <= bit_cnt_q + CNT_ONE;
                        if (bit_cnt_q == DW_LAST) begin
                            state_q   <= RECV;
                            bit_cnt_q <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // MISO follows the transmit MSB only while sending, so read data appears right after EXEC.
    always_comb begin
        if (state_q == SEND) begin
            MISO = tx_q[DATA_WIDTH-1];
        end else begin
            MISO = 1'b0;
        end
    end

    assign busy      = busy_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_ram_bridge.sv
// Randomised bench for spi_ram_bridge: three configurations against a frame-level
// model of the address registers and memory.
module tb_spi_ram_bridge;

    localparam int DW = 8;
    localparam int FW = DW + 2;
    localparam int NI = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NI-1:0]  ss_n;
    logic [NI-1:0]  mosi;
    wire  [NI-1:0]  miso;
    wire  [NI-1:0]  busy;
    wire  [NI-1:0]  ferr;

    int total = 0;
    int bad   = 0;

    int         depth_c [NI] = '{256, 256, 200};
    bit         ainc_c  [NI] = '{1'b1, 1'b0, 1'b1};
    logic [7:0] m_mem   [NI][256];
    bit         m_val   [NI][256];
    logic [7:0] m_wa    [NI];
    logic [7:0] m_ra    [NI];

    always #5 clk = ~clk;

    spi_ram_bridge #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MEM_DEPTH(256), .AUTO_INC(1'b1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .SS_n(ss_n[0]), .MOSI(mosi[0]),
        .MISO(miso[0]), .busy(busy[0]), .frame_err(ferr[0]));
    spi_ram_bridge #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MEM_DEPTH(256), .AUTO_INC(1'b0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .SS_n(ss_n[1]), .MOSI(mosi[1]),
        .MISO(miso[1]), .busy(busy[1]), .frame_err(ferr[1]));
    spi_ram_bridge #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MEM_DEPTH(200), .AUTO_INC(1'b1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .SS_n(ss_n[2]), .MOSI(mosi[2]),
        .MISO(miso[2]), .busy(busy[2]), .frame_err(ferr[2]));

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] m_inc(input int i, input logic [7:0] a);
        if (!ainc_c[i]) return a;
        if (int'(a) == depth_c[i] - 1) return 8'h00;
        return a + 8'h01;
    endfunction

    // Frame-level effect of one completed command; for reads returns the word expected.
    task automatic m_apply(input int i, input logic [1:0] cmd, input logic [7:0] pl,
                           output logic [7:0] ev, output bit known);
        ev = 8'h00;
        known = 1'b0;
        case (cmd)
            2'b00: m_wa[i] = pl;
            2'b01: begin
                if (int'(m_wa[i]) < depth_c[i]) begin
                    m_mem[i][m_wa[i]] = pl;
                    m_val[i][m_wa[i]] = 1'b1;
                end
                m_wa[i] = m_inc(i, m_wa[i]);
            end
            2'b10: m_ra[i] = pl;
            default: begin
                if (int'(m_ra[i]) >= depth_c[i]) begin
                    ev = 8'h00;
                    known = 1'b1;
                end else begin
                    ev = m_mem[i][m_ra[i]];
                    known = m_val[i][m_ra[i]];
                end
                m_ra[i] = m_inc(i, m_ra[i]);
            end
        endcase
    endtask

    task automatic send_bits(input int i, input logic [1:0] cmd, input logic [7:0] pl, input int n);
        logic [FW-1:0] fr;
        logic leak;
        fr = {cmd, pl};
        leak = 1'b0;
        for (int b = 0; b < n; b++) begin
            mosi[i] = fr[FW-1-b];
            tick();
            leak = leak | miso[i];
        end
        check_eq("miso_quiet_recv", 32'(leak), 32'd0);
    endtask

    task automatic start(input int i);
        ss_n[i] = 1'b0;
        tick();
        check_eq("busy_start", 32'(busy[i]), 32'd1);
        check_eq("ferr_start", 32'(ferr[i]), 32'd0);
    endtask

    task automatic stop_clean(input int i);
        ss_n[i] = 1'b1;
        tick();
        check_eq("ferr_clean_end", 32'(ferr[i]), 32'd0);
        check_eq("busy_clean_end", 32'(busy[i]), 32'd0);
    endtask

    task automatic frame(input int i, input logic [1:0] cmd, input logic [7:0] pl, output logic [7:0] got);
        logic [7:0] ev;
        bit known;
        send_bits(i, cmd, pl, FW);
        mosi[i] = 1'($urandom);
        tick();
        m_apply(i, cmd, pl, ev, known);
        got = 8'h00;
        if (cmd == 2'b11) begin
            for (int b = 0; b < DW; b++) begin
                got = {got[6:0], miso[i]};
                mosi[i] = 1'($urandom);
                tick();
            end
            if (known) check_eq("rd_data", 32'(got), 32'(ev));
        end
        check_eq("busy_in_burst", 32'(busy[i]), 32'd1);
    endtask

    task automatic abort_recv(input int i, input logic [1:0] cmd, input logic [7:0] pl, input int k);
        send_bits(i, cmd, pl, k);
        ss_n[i] = 1'b1;
        tick();
        check_eq("ferr_abort_recv", 32'(ferr[i]), 32'd1);
        check_eq("busy_abort_recv", 32'(busy[i]), 32'd0);
        tick();
        check_eq("ferr_pulse_width", 32'(ferr[i]), 32'd0);
    endtask

    task automatic end_in_exec(input int i, input logic [1:0] cmd, input logic [7:0] pl);
        logic [7:0] ev;
        bit known;
        send_bits(i, cmd, pl, FW);
        ss_n[i] = 1'b1;
        tick();
        m_apply(i, cmd, pl, ev, known);
        check_eq("ferr_exec_end", 32'(ferr[i]), 32'd0);
        check_eq("busy_exec_end", 32'(busy[i]), 32'd0);
        check_eq("miso_exec_end", 32'(miso[i]), 32'd0);
    endtask

    task automatic abort_send(input int i, input int k);
        logic [7:0] ev;
        logic [7:0] got;
        bit known;
        send_bits(i, 2'b11, 8'($urandom), FW);
        tick();
        m_apply(i, 2'b11, 8'h00, ev, known);
        got = 8'h00;
        for (int b = 0; b < k; b++) begin
            got = {got[6:0], miso[i]};
            tick();
        end
        if (known && k > 0) check_eq("rd_partial", 32'(got), 32'(ev >> (DW - k)));
        ss_n[i] = 1'b1;
        tick();
        check_eq("ferr_abort_send", 32'(ferr[i]), 32'd1);
        check_eq("busy_abort_send", 32'(busy[i]), 32'd0);
        check_eq("miso_after_abort", 32'(miso[i]), 32'd0);
        tick();
        check_eq("ferr_pulse_width", 32'(ferr[i]), 32'd0);
    endtask

    function automatic logic [7:0] pick_addr();
        case ($urandom_range(0, 3))
            0: return 8'($urandom_range(0, 7));
            1: return 8'($urandom_range(248, 255));
            2: return 8'($urandom_range(192, 207));
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] got;
        logic [1:0] cmd;
        logic [7:0] pl;
        int i;
        int nf;

        for (int n = 0; n < NI; n++) begin
            m_wa[n] = 8'h00;
            m_ra[n] = 8'h00;
            for (int a = 0; a < 256; a++) m_val[n][a] = 1'b0;
        end
        rst_n = 1'b0;
        ss_n  = '1;
        mosi  = '0;
        tick();
        tick();
        for (int n = 0; n < NI; n++) begin
            check_eq("rst_busy", 32'(busy[n]), 32'd0);
            check_eq("rst_ferr", 32'(ferr[n]), 32'd0);
            check_eq("rst_miso", 32'(miso[n]), 32'd0);
        end
        rst_n = 1'b1;
        tick();

        // Reset during bit 4 of a frame, then a clean decode.
        start(0);
        send_bits(0, 2'b00, 8'h10, 4);
        rst_n = 1'b0;
        tick();
        check_eq("midrst_busy", 32'(busy[0]), 32'd0);
        check_eq("midrst_ferr", 32'(ferr[0]), 32'd0);
        check_eq("midrst_miso", 32'(miso[0]), 32'd0);
        tick();
        rst_n = 1'b1;
        ss_n[0] = 1'b1;
        for (int n = 0; n < NI; n++) begin
            m_wa[n] = 8'h00;
            m_ra[n] = 8'h00;
        end
        tick();
        check_eq("postrst_ferr", 32'(ferr[0]), 32'd0);
        check_eq("postrst_busy", 32'(busy[0]), 32'd0);
        start(0);
        frame(0, 2'b00, 8'h10, got);
        frame(0, 2'b01, 8'h5A, got);
        frame(0, 2'b10, 8'h10, got);
        frame(0, 2'b11, 8'h00, got);
        check_eq("postrst_rd", 32'(got), 32'h5A);
        stop_clean(0);

        // Write/read-back in one burst.
        start(0);
        frame(0, 2'b00, 8'h05, got);
        frame(0, 2'b01, 8'hA5, got);
        frame(0, 2'b10, 8'h05, got);
        frame(0, 2'b11, 8'h00, got);
        check_eq("wr_rd_a5", 32'(got), 32'hA5);
        stop_clean(0);

        // Auto-increment wrap at the top of memory.
        start(0);
        frame(0, 2'b00, 8'hFF, got);
        frame(0, 2'b01, 8'h11, got);
        frame(0, 2'b01, 8'h22, got);
        frame(0, 2'b10, 8'hFF, got);
        frame(0, 2'b11, 8'h00, got);
        check_eq("wrap_rd_ff", 32'(got), 32'h11);
        frame(0, 2'b11, 8'h00, got);
        check_eq("wrap_rd_00", 32'(got), 32'h22);
        stop_clean(0);

        // Abort after 5 bits of WR_DATA leaves memory and wr_addr alone.
        start(0);
        frame(0, 2'b00, 8'h40, got);
        frame(0, 2'b01, 8'h12, got);
        stop_clean(0);
        start(0);
        abort_recv(0, 2'b01, 8'h3C, 5);
        start(0);
        frame(0, 2'b01, 8'h56, got);
        frame(0, 2'b10, 8'h40, got);
        frame(0, 2'b11, 8'h00, got);
        check_eq("abort_rd_40", 32'(got), 32'h12);
        frame(0, 2'b11, 8'h00, got);
        check_eq("abort_rd_41", 32'(got), 32'h56);
        stop_clean(0);

        // Address held without auto-increment.
        start(1);
        frame(1, 2'b00, 8'h21, got);
        frame(1, 2'b01, 8'h5B, got);
        frame(1, 2'b00, 8'h20, got);
        frame(1, 2'b01, 8'h33, got);
        frame(1, 2'b01, 8'h44, got);
        frame(1, 2'b10, 8'h20, got);
        frame(1, 2'b11, 8'h00, got);
        check_eq("noinc_rd_20", 32'(got), 32'h44);
        frame(1, 2'b11, 8'h00, got);
        check_eq("noinc_rd_20_again", 32'(got), 32'h44);
        frame(1, 2'b10, 8'h21, got);
        frame(1, 2'b11, 8'h00, got);
        check_eq("noinc_rd_21", 32'(got), 32'h5B);
        stop_clean(1);

        // Depth 200: out-of-range drop/zero read and wrap at 199.
        start(2);
        frame(2, 2'b00, 8'hF0, got);
        frame(2, 2'b01, 8'h77, got);
        frame(2, 2'b10, 8'hF0, got);
        frame(2, 2'b11, 8'h00, got);
        check_eq("oor_rd_zero", 32'(got), 32'h00);
        frame(2, 2'b00, 8'hC7, got);
        frame(2, 2'b01, 8'hAB, got);
        frame(2, 2'b01, 8'hCD, got);
        frame(2, 2'b10, 8'hC7, got);
        frame(2, 2'b11, 8'h00, got);
        check_eq("d200_rd_c7", 32'(got), 32'hAB);
        frame(2, 2'b11, 8'h00, got);
        check_eq("d200_rd_00", 32'(got), 32'hCD);
        stop_clean(2);

        // Randomised bursts with mixed endings.
        for (int t = 0; t < 150; t++) begin
            i = $urandom_range(0, NI - 1);
            start(i);
            nf = $urandom_range(1, 6);
            for (int f = 0; f < nf; f++) begin
                cmd = 2'($urandom_range(0, 3));
                pl  = (cmd[0] == 1'b0) ? pick_addr() : 8'($urandom);
                frame(i, cmd, pl, got);
            end
            case ($urandom_range(0, 3))
                0: stop_clean(i);
                1: abort_recv(i, 2'($urandom_range(0, 3)), 8'($urandom), $urandom_range(1, FW - 1));
                2: end_in_exec(i, 2'($urandom_range(0, 3)), pick_addr());
                default: abort_send(i, $urandom_range(0, DW - 1));
            endcase
            for (int w = 0; w < $urandom_range(0, 2); w++) tick();
            check_eq("busy_idle", 32'(busy[i]), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
